// File: rtl/pcpi_result_serializer_pkg.sv
// Shared definitions for the nibble-serial host link (loader and result side).
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package pcpi_result_serializer_pkg;

  // Width of one host-link nibble. Nibble 0 always carries bits [3:0].
  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    SEND     = 2'b01,
    WAIT_LOW = 2'b10
  } ser_state_t;

endpackage : pcpi_result_serializer_pkg

// File: rtl/pcpi_result_serializer_sync_2ff.sv
// Two-flop synchronizer for one asynchronous pin into the clk domain.
// Latency: 2 clk edges from pin change to q_o.
// Backpressure: none; the pin is sampled every cycle.
// Ports: clk_i, rst_ni (async active-low, clears both flops), d_i (async pin), q_o (synchronized).
module sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule : sync_2ff

// File: rtl/pcpi_result_serializer.sv
// Captures a PCPI write-back result and returns it to the host one nibble at a time.
// Latency: out_valid rises the cycle after capture; each nibble costs >= 6 cycles of 4-phase handshake.
// Backpressure: busy holds off the loader; a result arriving while busy is dropped and flags overrun.
// Ports: clk, rst_n (async active-low); pcpi_ready/pcpi_wr/pcpi_rd (write-back capture);
//        host_ack (async host pin); out_nibble/out_valid (host data), busy, done (1-cycle pulse), overrun (sticky).
module pcpi_result_serializer
  import pcpi_result_serializer_pkg::*;
#(
  parameter int DATA_W  = 32,  // must equal NIBBLES*NIBBLE_W
  parameter int NIBBLES = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pcpi_ready,
  input  logic              pcpi_wr,
  input  logic [DATA_W-1:0] pcpi_rd,
  input  logic              host_ack,
  output logic [3:0]        out_nibble,
  output logic              out_valid,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  localparam int CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

  ser_state_t              state_q, state_d;
  logic [DATA_W-1:0]       shreg_q, shreg_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [NIBBLE_W-1:0]     out_nibble_q, out_nibble_d;
  logic                    out_valid_q, out_valid_d;
  logic                    done_q, done_d;
  logic                    overrun_q, overrun_d;
  logic                    ack_s;
  logic                    cap;

  // The raw host pin is only ever seen through the synchronizer.
  sync_2ff u_ack_sync (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .d_i    (host_ack),
    .q_o    (ack_s)
  );

  assign cap = pcpi_ready & pcpi_wr;

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    count_d      = count_q;
    out_nibble_d = out_nibble_q;
    out_valid_d  = out_valid_q;
    done_d       = 1'b0;
    // Any capture outside IDLE (including the edge leaving WAIT_LOW) is a drop.
    overrun_d    = overrun_q | (cap & (state_q != IDLE));

    unique case (state_q)
      IDLE: begin
        if (cap) begin
          shreg_d      = pcpi_rd;
          out_nibble_d = pcpi_rd[NIBBLE_W-1:0];
          count_d      = '0;
          out_valid_d  = 1'b1;
          state_d      = SEND;
        end
      end
      SEND: begin
        out_valid_d = 1'b1;
        if (ack_s) begin
          out_valid_d = 1'b0;
          state_d     = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        if (!ack_s) begin
          if (count_q == LAST_CNT) begin
            // Last nibble released: out_nibble keeps its final value.
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            // The next nibble is loaded on the same edge out_valid rises,
            // so the data is never seen changing under a valid strobe.
            count_d      = count_q + CNT_W'(1);
            shreg_d      = shreg_q >> NIBBLE_W;
            out_nibble_d = shreg_q[2*NIBBLE_W-1:NIBBLE_W];
            out_valid_d  = 1'b1;
            state_d      = SEND;
          end
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      count_q      <= '0;
      out_nibble_q <= '0;
      out_valid_q  <= 1'b0;
      done_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      count_q      <= count_d;
      out_nibble_q <= out_nibble_d;
      out_valid_q  <= out_valid_d;
      done_q       <= done_d;
      overrun_q    <= overrun_d;
    end
  end

  assign out_nibble = out_nibble_q;
  assign out_valid  = out_valid_q;
  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign overrun    = overrun_q;

endmodule : pcpi_result_serializer

// File: tb/tb_pcpi_result_serializer.sv
// Self-checking bench for pcpi_result_serializer with a nibble scoreboard.
// Latency: n/a (testbench).
// Backpressure: host model paces the 4-phase handshake with programmable hold times.
module tb_pcpi_result_serializer;

  logic        clk;
  logic        rst_n;
  logic        pcpi_ready;
  logic        pcpi_wr;
  logic [31:0] pcpi_rd;
  logic        host_ack;
  logic [3:0]  out_nibble;
  logic        out_valid;
  logic        busy;
  logic        done;
  logic        overrun;

  int checks;
  int errors;

  logic [3:0] sb[$];
  int  rise_cnt;
  bit  host_en;
  int  ack_hi;
  int  ack_lo;

  pcpi_result_serializer #(.DATA_W(32), .NIBBLES(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pcpi_ready (pcpi_ready),
    .pcpi_wr    (pcpi_wr),
    .pcpi_rd    (pcpi_rd),
    .host_ack   (host_ack),
    .out_nibble (out_nibble),
    .out_valid  (out_valid),
    .busy       (busy),
    .done       (done),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Host model: acks a valid nibble, holds ack ack_hi cycles (and until valid drops), then low ack_lo cycles.
  task automatic host_model();
    forever begin
      @(negedge clk);
      if (host_en && rst_n && out_valid) begin
        host_ack = 1'b1;
        repeat (ack_hi) @(negedge clk);
        for (int k = 0; k < 100 && out_valid; k++) @(negedge clk);
        host_ack = 1'b0;
        repeat (ack_lo) @(negedge clk);
      end
    end
  endtask

  // Stream monitor: pops the scoreboard on each out_valid rise, checks stability and ack-to-release latency.
  task automatic stream_monitor();
    bit         valid_prev = 1'b0;
    bit         ack_prev   = 1'b0;
    bit         done_prev  = 1'b0;
    logic [3:0] held       = 4'h0;
    logic [3:0] exp;
    int         cyc        = 0;
    int         ack_cyc    = -100;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (rst_n) begin
        if (host_ack && !ack_prev) ack_cyc = cyc;
        if (out_valid && !valid_prev) begin
          rise_cnt++;
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL nibble_unexpected: got %h, none expected", out_nibble);
          end else begin
            exp = sb.pop_front();
            if (out_nibble !== exp) begin
              errors++;
              $display("FAIL nibble_value: got %h, required %h", out_nibble, exp);
            end
          end
          held = out_nibble;
        end else if (out_valid && valid_prev) begin
          checks++;
          if (out_nibble !== held) begin
            errors++;
            $display("FAIL nibble_stable: got %h, required %h", out_nibble, held);
          end
        end
        if (!out_valid && valid_prev) begin
          checks++;
          if (cyc - ack_cyc < 2) begin
            errors++;
            $display("FAIL ack_sync_latency: valid fell %0d edges after ack, required >= 2", cyc - ack_cyc);
          end
        end
        if (done && done_prev) begin
          checks++;
          errors++;
          $display("FAIL done_width: done high 2 consecutive cycles, required 1");
        end
      end
      valid_prev = out_valid;
      ack_prev   = host_ack;
      done_prev  = done;
    end
  endtask

  // Called at a negedge: presents the write-back for one clock edge.
  task automatic pulse_pcpi(input logic wr, input logic [31:0] data);
    pcpi_ready = 1'b1;
    pcpi_wr    = wr;
    pcpi_rd    = data;
    @(negedge clk);
    pcpi_ready = 1'b0;
    pcpi_wr    = 1'b0;
    pcpi_rd    = 32'h0;
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 0; i < 8; i++) sb.push_back(w[4*i +: 4]);
  endtask

  task automatic wait_done(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_rises(input int target, input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (rise_cnt >= target) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++;
    if ({out_nibble, out_valid, busy, done, overrun} !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: got %b, required 00000000", {out_nibble, out_valid, busy, done, overrun});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({out_valid, busy, done, overrun} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_idle: got %b, required 0000", {out_valid, busy, done, overrun});
    end
  endtask

  task automatic test_basic();
    bit got;
    int base;
    base    = rise_cnt;
    ack_hi  = 1;
    ack_lo  = 0;
    host_en = 1'b1;
    push_word(32'h89AB_CDEF);
    pulse_pcpi(1'b1, 32'h89AB_CDEF);
    got = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL basic_busy: got %b, required 1 (cycle %0d)", busy, i);
      end
      @(negedge clk);
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL basic_done_timeout: done not seen, required within 1000 cycles");
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy_at_done: got %b, required 0", busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_pulse: got %b one cycle later, required 0", done);
    end
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL basic_overrun: got %b, required 0", overrun);
    end
    checks++;
    if (rise_cnt - base != 8 || sb.size() != 0) begin
      errors++;
      $display("FAIL basic_count: got %0d rises / %0d pending, required 8 / 0", rise_cnt - base, sb.size());
    end
  endtask

  task automatic test_no_writeback();
    int base;
    base = rise_cnt;
    pulse_pcpi(1'b0, 32'hFFFF_FFFF);
    for (int i = 0; i < 20; i++) begin
      checks++;
      if ({busy, out_valid, done} !== 3'b000) begin
        errors++;
        $display("FAIL nowb_quiet: busy/valid/done got %b, required 000 (cycle %0d)", {busy, out_valid, done}, i);
      end
      @(negedge clk);
    end
    checks++;
    if (rise_cnt != base) begin
      errors++;
      $display("FAIL nowb_rises: got %0d, required 0", rise_cnt - base);
    end
  endtask

  task automatic test_back_to_back();
    bit got;
    int base;
    base = rise_cnt;
    push_word(32'h0F1E_2D3C);
    pulse_pcpi(1'b1, 32'h0F1E_2D3C);
    wait_done(1000, got);
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL b2b_first_timeout: done not seen, required within 1000 cycles");
    end
    // Still at the negedge inside the done cycle: this write-back lands on the following edge.
    push_word(32'h4B5A_6978);
    pulse_pcpi(1'b1, 32'h4B5A_6978);
    checks++;
    if (busy !== 1'b1 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept: busy/overrun got %b%b, required 10", busy, overrun);
    end
    wait_done(1000, got);
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL b2b_second_timeout: done not seen, required within 1000 cycles");
    end
    checks++;
    if (rise_cnt - base != 16 || sb.size() != 0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL b2b_total: got %0d rises / %0d pending / ovr %b, required 16 / 0 / 0",
               rise_cnt - base, sb.size(), overrun);
    end
  endtask

  task automatic test_slow_host();
    bit got;
    int base;
    base   = rise_cnt;
    ack_hi = 10;
    ack_lo = 7;
    push_word(32'hC3A5_5A3C);
    pulse_pcpi(1'b1, 32'hC3A5_5A3C);
    wait_done(3000, got);
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL slow_timeout: done not seen, required within 3000 cycles");
    end
    repeat (10) @(negedge clk);
    checks++;
    if (rise_cnt - base != 8 || sb.size() != 0) begin
      errors++;
      $display("FAIL slow_count: got %0d rises / %0d pending, required 8 / 0", rise_cnt - base, sb.size());
    end
    ack_hi = 1;
    ack_lo = 0;
  endtask

  task automatic test_overrun();
    bit got;
    int base;
    base = rise_cnt;
    push_word(32'h1234_5678);
    pulse_pcpi(1'b1, 32'h1234_5678);
    wait_rises(base + 4, 1000, got);
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL ovr_nibble3_timeout: got %0d rises, required 4", rise_cnt - base);
    end
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL ovr_before: got %b, required 0", overrun);
    end
    pulse_pcpi(1'b1, 32'hDEAD_BEEF);
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL ovr_set: got %b, required 1", overrun);
    end
    wait_done(1000, got);
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL ovr_done_timeout: done not seen, required within 1000 cycles");
    end
    repeat (3) @(negedge clk);
    checks++;
    if (overrun !== 1'b1 || rise_cnt - base != 8 || sb.size() != 0) begin
      errors++;
      $display("FAIL ovr_after: ovr %b, %0d rises, %0d pending, required 1, 8, 0", overrun, rise_cnt - base, sb.size());
    end
  endtask

  task automatic test_reset_mid();
    bit got;
    int base;
    base = rise_cnt;
    push_word(32'h7654_3210);
    pulse_pcpi(1'b1, 32'h7654_3210);
    wait_rises(base + 5, 1000, got);
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL rstmid_nibble4_timeout: got %0d rises, required 5", rise_cnt - base);
    end
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    host_en = 1'b0;
    #1;
    checks++;
    if ({out_nibble, out_valid, busy, done, overrun} !== 8'h00) begin
      errors++;
      $display("FAIL rstmid_async: got %b, required 00000000", {out_nibble, out_valid, busy, done, overrun});
    end
    sb.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (200) begin
      if (!host_ack) break;
      @(negedge clk);
    end
    repeat (5) @(negedge clk);
    checks++;
    if ({host_ack, out_valid, busy, overrun} !== 4'b0000) begin
      errors++;
      $display("FAIL rstmid_settle: ack/valid/busy/ovr got %b, required 0000", {host_ack, out_valid, busy, overrun});
    end
    host_en = 1'b1;
    base = rise_cnt;
    push_word(32'h0000_000A);
    pulse_pcpi(1'b1, 32'h0000_000A);
    wait_done(1000, got);
    checks++;
    if (!got || rise_cnt - base != 8 || sb.size() != 0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_fresh: done %b, %0d rises, %0d pending, ovr %b, required 1, 8, 0, 0",
               got, rise_cnt - base, sb.size(), overrun);
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rise_cnt   = 0;
    host_en    = 1'b0;
    ack_hi     = 1;
    ack_lo     = 0;
    host_ack   = 1'b0;
    pcpi_ready = 1'b0;
    pcpi_wr    = 1'b0;
    pcpi_rd    = 32'h0;
    rst_n      = 1'b0;
    fork
      host_model();
      stream_monitor();
    join_none
    test_reset();
    test_basic();
    test_no_writeback();
    test_back_to_back();
    test_slow_host();
    test_overrun();
    test_reset_mid();
    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_pcpi_result_serializer
